mcash_xbar_req_router: RTL and testbench
========================================

// Module: mcash_xbar_req_router
// PURPOSE
//  Parametrised request crossbar for mcash. It routes CH_NUM channel request streams to BANK_NUM bank HTU ports.
//  Each channel has an input FIFO. Each bank has a round-robin arbiter and a registered output slot.
//  It sits between the channel request ports and the bank wrapper HTU inputs.
//  Write data is not carried here: only op, addr and wbuffer id are routed.
// PARAMETERS
//  CH_NUM      3  number of request channels, 2..8
//  BANK_NUM    4  number of banks, power of two, 2..8; BW = log2(BANK_NUM)
//  FIFO_DEPTH  2  per-channel input FIFO entries, power of two, >=2
//  OP_W        2  opcode width
//  WID_W       8  wbuffer id width
//  BANK_HASH   0  0: bank = addr[4+:BW]; 1: bank = addr[4+:BW] ^ addr[12+:BW]
// PORTS
//  clk_i           in   1              clock
//  rst_i           in   1              synchronous active-high reset
//  ch_req_valid_i  in   CH_NUM         channel c request valid (bit c)
//  ch_req_allowIn_o out  CH_NUM         channel c may push this cycle
//  ch_req_op_i     in   CH_NUM*OP_W    opcode, channel c at [c*OP_W+:OP_W]
//  ch_req_addr_i   in   CH_NUM*28      line address [31:4], channel c at [c*28+:28]
//  ch_req_wid_i    in   CH_NUM*WID_W   wbuffer id
//  bank_valid_o    out  BANK_NUM       bank b request valid
//  bank_allowIn_i  in   BANK_NUM       bank b HTU accepts
//  bank_ch_id_o    out  BANK_NUM*3     source channel of bank b request
//  bank_opcode_o   out  BANK_NUM*OP_W  opcode
//  bank_addr_o     out  BANK_NUM*28    line address [31:4]
//  bank_wid_o      out  BANK_NUM*WID_W wbuffer id
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge)
//  - All FIFOs empty; all bank_valid_o=0; all RR pointers=0.
//  - ch_req_allowIn_o=0 while rst_i=1. bank payload outputs are don't-care while invalid.
//  - Reset mid-operation discards all queued and staged requests; nothing is replayed.
//  Channel side
//  - allowIn[c] = !rst_i && FIFO c not full. It depends on registered state only, never on valid_i.
//  - Push when valid&allowIn. A push and a pop on the same FIFO in the same cycle are both performed.
//  - A full FIFO with a pop does not raise allowIn in the same cycle.
//  - FIFO pointers wrap modulo FIFO_DEPTH. An extra bit distinguishes full from empty.
//  Routing
//  - The head of FIFO c targets bank tgt(c), computed from the head addr per BANK_HASH.
//  - Strict per-channel ordering. The head blocks its channel even if later entries target idle banks.
//  Per-bank arbitration (combinational, each cycle)
//  - Bank slot b is free when !bank_valid_o[b] || bank_allowIn_i[b].
//  - Requesters: channels with non-empty FIFO and tgt(c)==b.
//  - If the slot is free, grant one requester round-robin starting at ptr[b].
//  - On a grant to channel k: pop FIFO k; load the slot with {k, op, addr, wid}; ptr[b] <= (k+1) mod CH_NUM.
//  - ptr[b] is unchanged when there is no grant.
//  - One channel can target only one bank per cycle, so there are no double pops.
//  Output slot
//  - bank_valid_o holds with a stable payload until bank_allowIn_i=1.
//  - Drain and reload in the same cycle gives back-to-back valids (full throughput per bank).
//  - With no grant, valid clears on drain.
//  Latency
//  - Push in cycle T -> bank_valid_o in cycle T+2 minimum, when the FIFO was empty and the slot free.
//  Throughput
//  - Up to min(CH_NUM, BANK_NUM) requests per cycle when targets are disjoint.
//  ch_id encoding: zero-extended channel index, 3 bits.
// TESTING
//  1 Reset, then ch0 pushes addr=0x0000002 (bank2) op=1 wid=0x15 at T, bank2 allowIn=1
//    -> bank_valid_o[2]=1 at T+2 with ch_id=0, op=1, wid=0x15; other banks stay 0.
//  2 ch0, ch1, ch2 each push addr bank 1 every cycle, bank1 allowIn=1
//    -> grant order 0,1,2,0,1,2...; one valid per cycle on bank1.
//  3 Bank3 allowIn=0, ch1 pushes 3 reqs to bank3 (DEPTH=2)
//    -> allowIn_o[1] low after slot+FIFO fill (3 accepted); payload holds stable.
//    -> Raise allowIn: drains in order.
//  4 ch0 head targets stalled bank0, ch0 second req targets bank1
//    -> bank1 gets nothing until bank0 drains (HOL order).
//    -> ch2 to bank1 is served meanwhile.
//  5 BANK_HASH=1, addr[31:4]=0x0000101
//    -> routed to bank 0 (1^1); addr 0x0000001 -> bank 1.
//  6 Assert rst_i for one cycle with all FIFOs full and all slots valid
//    -> next cycle all bank_valid_o=0, allowIn=all ones; the next grant starts at ch0.

Source files
------------

// File: rtl/mcash_xbar_req_router.sv
// Request crossbar: per-channel input FIFOs feed per-bank round-robin arbiters,
// each bank presenting its winner from a registered output slot.
module mcash_xbar_req_router #(
  parameter int CH_NUM     = 3,
  parameter int BANK_NUM   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int OP_W       = 2,
  parameter int WID_W      = 8,
  parameter int BANK_HASH  = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CH_NUM-1:0]         ch_req_valid_i,
  output logic [CH_NUM-1:0]         ch_req_allowIn_o,
  input  logic [CH_NUM*OP_W-1:0]    ch_req_op_i,
  input  logic [CH_NUM*28-1:0]      ch_req_addr_i,
  input  logic [CH_NUM*WID_W-1:0]   ch_req_wid_i,
  output logic [BANK_NUM-1:0]       bank_valid_o,
  input  logic [BANK_NUM-1:0]       bank_allowIn_i,
  output logic [BANK_NUM*3-1:0]     bank_ch_id_o,
  output logic [BANK_NUM*OP_W-1:0]  bank_opcode_o,
  output logic [BANK_NUM*28-1:0]    bank_addr_o,
  output logic [BANK_NUM*WID_W-1:0] bank_wid_o
);
  localparam int BW = $clog2(BANK_NUM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(CH_NUM);
  localparam int EW = OP_W + 28 + WID_W;

  // entry layout: {op, addr, wid}
  logic [EW-1:0]       fifo_mem [CH_NUM][FIFO_DEPTH];
  logic [AW:0]         wr_ptr [CH_NUM];
  logic [AW:0]         rd_ptr [CH_NUM];
  logic [CH_NUM-1:0]   empty;
  logic [CH_NUM-1:0]   full;
  logic [CH_NUM-1:0]   push;
  logic [CH_NUM-1:0]   pop;
  logic [EW-1:0]       head [CH_NUM];
  logic [BW-1:0]       tgt [CH_NUM];

  logic [PW-1:0]       rr_ptr [BANK_NUM];
  logic [PW-1:0]       rr_next [BANK_NUM];
  logic [CH_NUM-1:0]   req_hi [BANK_NUM];
  logic [CH_NUM-1:0]   req_lo [BANK_NUM];
  logic [CH_NUM-1:0]   grant [BANK_NUM];
  logic [2:0]          sel_ch [BANK_NUM];
  logic [EW-1:0]       grant_data [BANK_NUM];
  logic [BANK_NUM-1:0] grant_any;

  logic [BANK_NUM-1:0] slot_valid;
  logic [2:0]          slot_ch [BANK_NUM];
  logic [EW-1:0]       slot_data [BANK_NUM];

  // FIFO status, head entry and its target bank; allowIn sees only registered state
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                 (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
      head[c]  = fifo_mem[c][rd_ptr[c][AW-1:0]];
      tgt[c]   = head[c][WID_W +: BW] ^
                 ((BANK_HASH != 0) ? head[c][WID_W+8 +: BW] : {BW{1'b0}});
      ch_req_allowIn_o[c] = !rst_i && !full[c];
      push[c] = ch_req_valid_i[c] && ch_req_allowIn_o[c];
    end
  end

  // Per-bank round-robin: requesters at or above ptr win over those below it
  always_comb begin
    pop = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      req_hi[b]     = '0;
      req_lo[b]     = '0;
      grant[b]      = '0;
      sel_ch[b]     = 3'd0;
      grant_data[b] = '0;
      rr_next[b]    = rr_ptr[b];
      for (int k = 0; k < CH_NUM; k++) begin
        req_hi[b][k] = !empty[k] && (tgt[k] == BW'(b)) && (k >= int'(rr_ptr[b]));
        req_lo[b][k] = !empty[k] && (tgt[k] == BW'(b)) && (k < int'(rr_ptr[b]));
      end
      for (int k = CH_NUM - 1; k >= 0; k--) begin
        sel_ch[b] = req_lo[b][k] ? 3'(k) : sel_ch[b];
      end
      for (int k = CH_NUM - 1; k >= 0; k--) begin
        sel_ch[b] = req_hi[b][k] ? 3'(k) : sel_ch[b];
      end
      grant_any[b] = (!slot_valid[b] || bank_allowIn_i[b]) && (|{req_hi[b], req_lo[b]});
      for (int k = 0; k < CH_NUM; k++) begin
        grant[b][k]   = grant_any[b] && (int'(sel_ch[b]) == k);
        grant_data[b] = grant[b][k] ? head[k] : grant_data[b];
        rr_next[b]    = grant[b][k] ? PW'((k + 1) % CH_NUM) : rr_next[b];
      end
      pop = pop | grant[b];
    end
  end

  // Control state: FIFO pointers, arbiter pointers and slot valids
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      for (int b = 0; b < BANK_NUM; b++) begin
        rr_ptr[b] <= '0;
      end
      slot_valid <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
      end
      for (int b = 0; b < BANK_NUM; b++) begin
        rr_ptr[b] <= rr_next[b];
        if (grant_any[b]) begin
          slot_valid[b] <= 1'b1;
        end else if (bank_allowIn_i[b]) begin
          slot_valid[b] <= 1'b0;
        end else begin
          slot_valid[b] <= slot_valid[b];
        end
      end
    end
  end

  // Payload storage; contents are meaningless while the matching valid is low
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (push[c]) begin
        fifo_mem[c][wr_ptr[c][AW-1:0]] <= {ch_req_op_i[c*OP_W +: OP_W],
                                           ch_req_addr_i[c*28 +: 28],
                                           ch_req_wid_i[c*WID_W +: WID_W]};
      end
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      if (grant_any[b]) begin
        slot_ch[b]   <= sel_ch[b];
        slot_data[b] <= grant_data[b];
      end
    end
  end

  // Flatten slot registers onto the bank ports
  always_comb begin
    bank_valid_o = slot_valid;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_ch_id_o[b*3 +: 3]        = slot_ch[b];
      bank_opcode_o[b*OP_W +: OP_W] = slot_data[b][WID_W+28 +: OP_W];
      bank_addr_o[b*28 +: 28]       = slot_data[b][WID_W +: 28];
      bank_wid_o[b*WID_W +: WID_W]  = slot_data[b][0 +: WID_W];
    end
  end

endmodule

// File: tb/tb_mcash_xbar_req_router.sv
// Scoreboard bench for mcash_xbar_req_router: two instances (plain and hashed
// bank select) share stimulus; a queue-based reference model predicts each bank.
module tb_mcash_xbar_req_router;
  localparam int CH = 3;
  localparam int BK = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0]  ch;
    logic [1:0]  op;
    logic [27:0] addr;
    logic [7:0]  wid;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   ch_valid;
  logic [CH*2-1:0] ch_op;
  logic [CH*28-1:0] ch_addr;
  logic [CH*8-1:0] ch_wid;
  logic [BK-1:0]   bank_allow;

  logic [CH-1:0]    allow_o [2];
  logic [BK-1:0]    bvalid [2];
  logic [BK*3-1:0]  bch [2];
  logic [BK*2-1:0]  bop [2];
  logic [BK*28-1:0] badr [2];
  logic [BK*8-1:0]  bwid [2];

  // reference model state, one copy per instance
  req_t fq [2][CH][$];
  bit   mv [2][BK];
  int   mp [2][BK];
  req_t exp_q [2][BK][$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mcash_xbar_req_router #(.CH_NUM(CH), .BANK_NUM(BK), .FIFO_DEPTH(DEPTH),
                          .OP_W(2), .WID_W(8), .BANK_HASH(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .ch_req_valid_i(ch_valid), .ch_req_allowIn_o(allow_o[0]),
    .ch_req_op_i(ch_op), .ch_req_addr_i(ch_addr), .ch_req_wid_i(ch_wid),
    .bank_valid_o(bvalid[0]), .bank_allowIn_i(bank_allow), .bank_ch_id_o(bch[0]),
    .bank_opcode_o(bop[0]), .bank_addr_o(badr[0]), .bank_wid_o(bwid[0]));

  mcash_xbar_req_router #(.CH_NUM(CH), .BANK_NUM(BK), .FIFO_DEPTH(DEPTH),
                          .OP_W(2), .WID_W(8), .BANK_HASH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .ch_req_valid_i(ch_valid), .ch_req_allowIn_o(allow_o[1]),
    .ch_req_op_i(ch_op), .ch_req_addr_i(ch_addr), .ch_req_wid_i(ch_wid),
    .bank_valid_o(bvalid[1]), .bank_allowIn_i(bank_allow), .bank_ch_id_o(bch[1]),
    .bank_opcode_o(bop[1]), .bank_addr_o(badr[1]), .bank_wid_o(bwid[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // line address -> bank: low two bits, optionally xor'd with bits 9:8
  function automatic int bank_of(int d, logic [27:0] a);
    int lo = int'(a % 28'd4);
    int hi = int'((a / 28'd256) % 28'd4);
    return (d == 1) ? (lo ^ hi) : lo;
  endfunction

  task automatic model_clear(int d);
    for (int c = 0; c < CH; c++) fq[d][c].delete();
    for (int b = 0; b < BK; b++) begin
      mv[d][b] = 1'b0;
      mp[d][b] = 0;
      exp_q[d][b].delete();
    end
  endtask

  // one clock edge of the reference model, applied to pre-edge state and inputs
  task automatic model_step(int d);
    int gk [BK];
    bit dp [CH];
    req_t r;
    if (rst) begin
      model_clear(d);
      return;
    end
    for (int b = 0; b < BK; b++) begin
      gk[b] = -1;
      if (!mv[d][b] || bank_allow[b]) begin
        for (int i = 0; i < CH; i++) begin
          int k = (mp[d][b] + i) % CH;
          if (gk[b] < 0 && fq[d][k].size() > 0 && bank_of(d, fq[d][k][0].addr) == b) gk[b] = k;
        end
      end
    end
    for (int c = 0; c < CH; c++) dp[c] = ch_valid[c] && (fq[d][c].size() < DEPTH);
    for (int b = 0; b < BK; b++) begin
      if (gk[b] >= 0) begin
        r = fq[d][gk[b]].pop_front();
        r.ch = 3'(gk[b]);
        mv[d][b] = 1'b1;
        mp[d][b] = (gk[b] + 1) % CH;
        exp_q[d][b].push_back(r);
      end else if (bank_allow[b]) begin
        mv[d][b] = 1'b0;
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (dp[c]) begin
        r.ch = 3'd0;
        r.op = ch_op[c*2 +: 2];
        r.addr = ch_addr[c*28 +: 28];
        r.wid = ch_wid[c*8 +: 8];
        fq[d][c].push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic set_ch(int c, bit v, logic [27:0] a, logic [1:0] op, logic [7:0] wid);
    ch_valid[c] = v;
    ch_addr[c*28 +: 28] = a;
    ch_op[c*2 +: 2] = op;
    ch_wid[c*8 +: 8] = wid;
  endtask

  task automatic rand_ch(int c, int pv, bit narrow);
    logic [27:0] a = 28'($urandom);
    if (narrow) a = a & 28'h0000303;
    set_ch(c, $urandom_range(99) < pv, a, 2'($urandom), 8'($urandom));
  endtask

  // monitor: compare against the model mid-cycle, pop the scoreboard on each handshake
  always begin
    req_t e;
    req_t got;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++)
        check($sformatf("allowIn d%0d ch%0d", d, c), 64'(allow_o[d][c]),
              64'(!rst && (fq[d][c].size() < DEPTH)));
      for (int b = 0; b < BK; b++) begin
        check($sformatf("valid d%0d bank%0d", d, b), 64'(bvalid[d][b]), 64'(mv[d][b]));
        if (bvalid[d][b] && bank_allow[b]) begin
          got = {bch[d][b*3 +: 3], bop[d][b*2 +: 2], badr[d][b*28 +: 28], bwid[d][b*8 +: 8]};
          if (exp_q[d][b].size() == 0) begin
            checks++;
            $display("FAIL unexpected d%0d bank%0d actual=%0h required=none", d, b, got);
          end else begin
            e = exp_q[d][b].pop_front();
            check($sformatf("payload d%0d bank%0d", d, b), 64'(got), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ch_valid = '0;
    ch_op = '0;
    ch_addr = '0;
    ch_wid = '0;
    bank_allow = '1;
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;

    // single request to bank 2
    set_ch(0, 1'b1, 28'h0000002, 2'd1, 8'h15);
    tick();
    ch_valid = '0;
    repeat (4) tick();

    // all channels hammer bank 1
    repeat (30) begin
      for (int c = 0; c < CH; c++)
        set_ch(c, 1'b1, (28'($urandom) << 10) | 28'h1, 2'($urandom), 8'($urandom));
      tick();
    end
    ch_valid = '0;
    repeat (4) tick();

    // bank 3 stalled while ch1 fills slot and FIFO, then released
    bank_allow = 4'b0111;
    repeat (6) begin
      set_ch(1, 1'b1, (28'($urandom) << 10) | 28'h3, 2'($urandom), 8'($urandom));
      tick();
    end
    ch_valid = '0;
    repeat (3) tick();
    bank_allow = '1;
    repeat (6) tick();

    // head-of-line: ch0 blocked behind stalled bank 0, ch2 still reaches bank 1
    bank_allow = 4'b1110;
    set_ch(0, 1'b1, 28'h0000010, 2'd0, 8'h01);
    tick();
    set_ch(0, 1'b1, 28'h0000020, 2'd1, 8'h02);
    tick();
    set_ch(0, 1'b1, 28'h0000001, 2'd2, 8'h03);
    set_ch(2, 1'b1, 28'h0000401, 2'd3, 8'h04);
    tick();
    ch_valid[0] = 1'b0;
    repeat (4) begin
      set_ch(2, 1'b1, (28'($urandom) << 10) | 28'h1, 2'($urandom), 8'($urandom));
      tick();
    end
    ch_valid = '0;
    repeat (2) tick();
    bank_allow = '1;
    repeat (6) tick();

    // hashed bank select corner addresses
    set_ch(0, 1'b1, 28'h0000101, 2'd1, 8'hA1);
    set_ch(1, 1'b1, 28'h0000102, 2'd2, 8'hA2);
    tick();
    set_ch(0, 1'b1, 28'h0000001, 2'd3, 8'hA3);
    ch_valid[1] = 1'b0;
    tick();
    ch_valid = '0;
    repeat (4) tick();

    // randomized traffic with varying load and backpressure
    for (int seg = 0; seg < 3; seg++) begin
      repeat (500) begin
        for (int c = 0; c < CH; c++) rand_ch(c, 30 + seg * 30, seg != 1);
        for (int b = 0; b < BK; b++) bank_allow[b] = ($urandom_range(99) < 90 - seg * 25);
        tick();
      end
    end

    // fill everything, then reset for one cycle
    bank_allow = '0;
    repeat (8) begin
      for (int c = 0; c < CH; c++) rand_ch(c, 100, 1'b1);
      tick();
    end
    rst = 1'b1;
    ch_valid = '0;
    tick();
    rst = 1'b0;
    bank_allow = '1;
    repeat (6) begin
      for (int c = 0; c < CH; c++)
        set_ch(c, 1'b1, (28'($urandom) << 10) | 28'h2, 2'($urandom), 8'($urandom));
      tick();
    end

    // drain and confirm every predicted request was delivered
    ch_valid = '0;
    bank_allow = '1;
    repeat (10) tick();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < BK; b++)
        check($sformatf("leftover d%0d bank%0d", d, b), 64'(exp_q[d][b].size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
